read_handler_fwft: RTL and testbench

Read-side pointer and flag controller for the asynchronous FIFO, running entirely in the read clock domain. It consumes the write-side Gray pointer after it has crossed through the two-flop synchroniser, and produces the read Gray pointer that is synchronised back to the write side. It drives the memory read address and presents data through a first-word-fall-through (FWFT) output register with a valid/ready handshake. An optional occupancy count and almost-empty flag are also provided.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/read_handler_fwft_gray_to_bin.sv | 14 +
 rtl/read_handler_fwft.sv | 86 ++++++++
 tb/tb_read_handler_fwft.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO defaults and Gray/binary conversion helpers.
package fifo_pkg;

    localparam int FIFO_N     = 3;
    localparam int FIFO_WIDTH = 8;

    // Generic 32-bit forms; callers size-cast to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/read_handler_fwft_gray_to_bin.sv
// gray_to_bin: combinational prefix-XOR Gray-to-binary converter.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    genvar i;
    for (i = 0; i < W; i++) begin : g_x
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/read_handler_fwft.sv
// read_handler_fwft: async-FIFO read pointer, empty flag and FWFT output register.
// Define FIFO_RD_COUNT_EN to add the registered rd_count / almost_empty outputs.
module read_handler_fwft
    import fifo_pkg::*;
#(
    parameter int N        = FIFO_N,
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int AE_LEVEL = 1
) (
    input  logic             r_clk,
    input  logic             r_reset,
    input  logic [N:0]       gwptrsyn,
    input  logic [WIDTH-1:0] rdata,
    input  logic             r_ready,
    output logic [N-1:0]     raddr,
    output logic [N:0]       grptr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic [N:0]       rd_count,
    output logic             almost_empty
);

    logic [N:0]       brptr_q, brptr_d, grptr_q, grptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d, empty_q, empty_d, fetch;

    // A fetch refills the output register whenever it is free or being drained.
    always_comb begin
        fetch        = !empty_q && (!dout_valid_q || r_ready);
        brptr_d      = brptr_q + (N+1)'(fetch);
        grptr_d      = (N+1)'(bin2gray(32'(brptr_d)));
        empty_d      = grptr_d == gwptrsyn;
        dout_d       = fetch ? rdata : dout_q;
        dout_valid_d = fetch || (dout_valid_q && !r_ready);
    end

    always_ff @(posedge r_clk) begin
        if (!r_reset) begin
            brptr_q      <= '0;
            grptr_q      <= '0;
            empty_q      <= 1'b1;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            brptr_q      <= brptr_d;
            grptr_q      <= grptr_d;
            empty_q      <= empty_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign raddr      = brptr_q[N-1:0];
    assign grptr      = grptr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign empty      = empty_q;

`ifdef FIFO_RD_COUNT_EN
    localparam logic [N:0] AE = (N+1)'(AE_LEVEL);
    logic [N:0] wbin, rd_count_d, rd_count_q;
    logic       almost_empty_q;

    gray_to_bin #(.W(N+1)) u_g2b (.gray_i(gwptrsyn), .bin_o(wbin));

    assign rd_count_d = wbin - brptr_d;

    always_ff @(posedge r_clk) begin
        if (!r_reset) begin
            rd_count_q     <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            rd_count_q     <= rd_count_d;
            almost_empty_q <= rd_count_d <= AE;
        end
    end

    assign rd_count     = rd_count_q;
    assign almost_empty = almost_empty_q;
`else
    assign rd_count     = '0;
    assign almost_empty = AE_LEVEL < 0;
`endif

endmodule

// File: tb/tb_read_handler_fwft.sv
// tb_read_handler_fwft: directed vector table plus stream, wrap and reset sequences.
module tb_read_handler_fwft;

    logic       r_clk = 1'b0;
    logic       r_reset = 1'b0;
    logic [3:0] gwptrsyn = 4'h1;
    logic [7:0] rdata;
    logic       r_ready = 1'b0;
    logic [2:0] raddr;
    logic [3:0] grptr;
    logic [7:0] dout;
    logic       dout_valid, empty;
    logic [3:0] rd_count;
    logic       almost_empty;

    logic [7:0] mem [8];
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] gw;
        logic       rdy;
        logic       e;
        logic       v;
        logic [7:0] d;
        logic [2:0] ra;
        logic [3:0] g;
    } vec_t;

    vec_t tv [16];

    read_handler_fwft #(.N(3), .WIDTH(8), .AE_LEVEL(1)) dut (
        .r_clk(r_clk), .r_reset(r_reset), .gwptrsyn(gwptrsyn), .rdata(rdata),
        .r_ready(r_ready), .raddr(raddr), .grptr(grptr), .dout(dout),
        .dout_valid(dout_valid), .empty(empty), .rd_count(rd_count),
        .almost_empty(almost_empty)
    );

    always #5 r_clk = ~r_clk;
    always_comb rdata = mem[raddr];

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g4(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    initial begin
        int ntx;
        logic [3:0] prev_g;
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'hA5 + 17 * i);
        tv[0]  = '{1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'h0};
        tv[1]  = '{1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'h0};
        tv[2]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'h0};
        tv[3]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 4'h0};
        tv[4]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 4'h1};
        tv[5]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 4'h1};
        for (int i = 6; i <= 10; i++)
            tv[i] = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1, 4'h1};
        tv[11] = '{1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 8'hB6, 3'd2, 4'h3};
        tv[12] = '{1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 8'hC7, 3'd3, 4'h2};
        tv[13] = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 8'hD8, 3'd4, 4'h6};
        tv[14] = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 8'hD8, 3'd4, 4'h6};
        tv[15] = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 8'hD8, 3'd4, 4'h6};

        for (int i = 0; i < 16; i++) begin
            r_reset = tv[i].rst_n;
            gwptrsyn = tv[i].gw;
            r_ready = tv[i].rdy;
            step();
            chk($sformatf("v%0d_empty", i), empty, tv[i].e);
            chk($sformatf("v%0d_valid", i), dout_valid, tv[i].v);
            chk($sformatf("v%0d_dout", i), dout, tv[i].d);
            chk($sformatf("v%0d_raddr", i), raddr, tv[i].ra);
            chk($sformatf("v%0d_grptr", i), grptr, tv[i].g);
`ifndef FIFO_RD_COUNT_EN
            chk($sformatf("v%0d_rd_count", i), rd_count, 0);
            chk($sformatf("v%0d_almost_empty", i), almost_empty, 0);
`endif
        end

        // Stream 20 words across the 15->0 pointer wrap, writer one word ahead per cycle.
        ntx = 0;
        prev_g = grptr;
        for (int c = 0; c < 100 && ntx < 20; c++) begin
            gwptrsyn = g4((5 + c > 24) ? 24 : 5 + c);
            if (grptr !== prev_g) chk("gray_step_bits", $countones(grptr ^ prev_g), 1);
            prev_g = grptr;
            if (dout_valid) begin
                chk($sformatf("stream_data%0d", ntx), dout, mem[(4 + ntx) % 8]);
                ntx++;
            end
            if (ntx < 20) step();
        end
        chk("stream_count", ntx, 20);
        chk("stream_end_grptr", grptr, 4'hC);
        chk("stream_end_raddr", raddr, 0);
        step();
        chk("stream_drain_valid", dout_valid, 0);
        chk("stream_drain_empty", empty, 1);

        // Reset while a word is presented and accepted.
        gwptrsyn = g4(27);
        step();
        step();
        for (int i = 0; i < 5 && !dout_valid; i++) step();
        chk("midrst_pre_valid", dout_valid, 1);
        r_reset = 1'b0;
        step();
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_raddr", raddr, 0);
        chk("midrst_grptr", grptr, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_dout", dout, 0);
        r_reset = 1'b1;
        gwptrsyn = 4'h0;
        step();
        step();
        chk("postrst_empty", empty, 1);
        chk("postrst_valid", dout_valid, 0);

`ifdef FIFO_RD_COUNT_EN
        r_ready = 1'b0;
        gwptrsyn = g4(8);
        step();
        chk("cnt_full", rd_count, 8);
        chk("cnt_full_ae", almost_empty, 0);
        r_ready = 1'b1;
        for (int i = 0; i < 20 && rd_count != 1; i++) step();
        chk("cnt_one", rd_count, 1);
        chk("cnt_one_ae", almost_empty, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
